// File: rtl/pipe_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_adder_if
// Brief    : Operand/result handshake bundle for the pipelined CLA adder.
// Revision : 1.0
// ============================================================================
interface pipe_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_adder
// Brief    : Add/subtract pipelined one 4-bit carry-lookahead slice per stage.
// Revision : 1.0
// ============================================================================
module pipe_cla_adder #(
   parameter int WIDTH = 16
) (
   input  wire logic       clk,
   input  wire logic       rst,
   pipe_cla_adder_if.slave bus
);
   localparam int STAGES = WIDTH / 4;
   localparam int LAST   = STAGES - 1;

   // Returns {carry_out, sum[3:0]} of a 4-bit carry-lookahead slice.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic             r_valid [STAGES];
   logic             r_carry [STAGES];
   logic [WIDTH-1:0] r_a     [STAGES];
   logic [WIDTH-1:0] r_b     [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];

   logic             w_v_in  [STAGES];
   logic             w_c_in  [STAGES];
   logic [WIDTH-1:0] w_a_in  [STAGES];
   logic [WIDTH-1:0] w_b_in  [STAGES];
   logic [WIDTH-1:0] w_s_in  [STAGES];
   logic [WIDTH-1:0] w_s_nxt [STAGES];
   logic             w_c_nxt [STAGES];
   logic             w_stall;

   assign w_stall = r_valid[LAST] & ~bus.out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [4:0] w_cla;

      if (k == 0) begin : g_first
         // B is inverted once on entry so every slice only ever adds.
         assign w_v_in[k] = bus.in_valid;
         assign w_a_in[k] = bus.a;
         assign w_b_in[k] = bus.sub ? ~bus.b : bus.b;
         assign w_c_in[k] = bus.sub | bus.cin;
         assign w_s_in[k] = '0;
      end else begin : g_next
         assign w_v_in[k] = r_valid[k-1];
         assign w_a_in[k] = r_a[k-1];
         assign w_b_in[k] = r_b[k-1];
         assign w_c_in[k] = r_carry[k-1];
         assign w_s_in[k] = r_sum[k-1];
      end

      assign w_cla      = cla4(w_a_in[k][4*k +: 4], w_b_in[k][4*k +: 4], w_c_in[k]);
      // Nibble k of the travelling sum is still zero here, so OR-in is enough.
      assign w_s_nxt[k] = w_s_in[k] | (WIDTH'(w_cla[3:0]) << (4 * k));
      assign w_c_nxt[k] = w_cla[4];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_carry[k] <= 1'b0;
            r_a[k]     <= '0;
            r_b[k]     <= '0;
            r_sum[k]   <= '0;
         end
      end else if (!w_stall) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= w_v_in[k];
            if (w_v_in[k]) begin
               r_carry[k] <= w_c_nxt[k];
               r_a[k]     <= w_a_in[k];
               r_b[k]     <= w_b_in[k];
               r_sum[k]   <= w_s_nxt[k];
            end
         end
      end
   end

   assign bus.in_ready  = ~w_stall;
   assign bus.out_valid = r_valid[LAST];
   assign bus.sum       = r_sum[LAST];
   assign bus.cout      = r_carry[LAST];
   assign bus.ovf       = (r_a[LAST][WIDTH-1] ~^ r_b[LAST][WIDTH-1])
                        & (r_sum[LAST][WIDTH-1] ^ r_a[LAST][WIDTH-1]);
endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_cla_adder
// Brief    : Directed and random checks of pipe_cla_adder at WIDTH 4/16/64.
// Revision : 1.0
// ============================================================================
module tb_pipe_cla_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_cla_adder_if #(.WIDTH(4))  if4  ();
   pipe_cla_adder_if #(.WIDTH(16)) if16 ();
   pipe_cla_adder_if #(.WIDTH(64)) if64 ();

   pipe_cla_adder #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4.slave));
   pipe_cla_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
   pipe_cla_adder #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(if64.slave));

   int          n_cmp = 0;
   int          n_err = 0;
   logic [65:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb, input logic ordy);
      case (sel)
         0: begin if4.in_valid = v; if4.a = a[3:0]; if4.b = b[3:0];
                  if4.cin = ci; if4.sub = sb; if4.out_ready = ordy; end
         1: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0];
                  if16.cin = ci; if16.sub = sb; if16.out_ready = ordy; end
         default: begin if64.in_valid = v; if64.a = a; if64.b = b;
                  if64.cin = ci; if64.sub = sb; if64.out_ready = ordy; end
      endcase
   endtask

   task automatic sample(input int sel, output logic rdy, output logic ov, output logic [63:0] s,
                         output logic co, output logic of);
      #1;
      case (sel)
         0: begin rdy = if4.in_ready; ov = if4.out_valid; s = {60'd0, if4.sum};
                  co = if4.cout; of = if4.ovf; end
         1: begin rdy = if16.in_ready; ov = if16.out_valid; s = {48'd0, if16.sum};
                  co = if16.cout; of = if16.ovf; end
         default: begin rdy = if64.in_ready; ov = if64.out_valid; s = if64.sum;
                  co = if64.cout; of = if64.ovf; end
      endcase
   endtask

   // Reference: {ovf, cout, sum} of a + b + cin, or a - b, at width w.
   function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic ci, input logic sb);
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bb;
      logic [64:0] full;
      logic [63:0] s;
      logic        o;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bb   = sb ? (~b & mask) : (b & mask);
      full = {1'b0, am} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
      s    = full[63:0] & mask;
      o    = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
      return {o, full[w], s};
   endfunction

   // One beat through the WIDTH=16 unit, checking latency and result.
   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo);
      logic        rdy, ov, co, of;
      logic [63:0] s;
      int          lat;
      drive(1, 1'b1, 64'(a), 64'(b), ci, sb, 1'b1);
      tick();
      drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      lat = 1;
      sample(1, rdy, ov, s, co, of);
      while (!ov && lat < 10) begin
         tick();
         lat++;
         sample(1, rdy, ov, s, co, of);
      end
      chk({tag, "_lat"}, 64'(lat), 64'd4);
      chk({tag, "_sum"}, s, 64'(es));
      chk({tag, "_cout"}, 64'(co), 64'(ec));
      chk({tag, "_ovf"}, 64'(of), 64'(eo));
      tick();
   endtask

   initial begin
      logic        rdy, ov, co, of, v, ordy, ci, sb, stale;
      logic [63:0] s, held, a, b;
      logic [65:0] e;
      int          sent, got, cyc, acc, w;

      for (int i = 0; i < 3; i++) drive(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);

      // Reset state, checked before any clock edge.
      #2;
      sample(1, rdy, ov, s, co, of);
      chk("rst_out_valid", 64'(ov), 64'd0);
      chk("rst_sum", s, 64'd0);
      chk("rst_cout", 64'(co), 64'd0);
      chk("rst_ovf", 64'(of), 64'd0);
      chk("rst_in_ready", 64'(rdy), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First edge after release accepts the beat.
      run_one("add_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
      run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("add_cin", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
      run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Eight back-to-back beats (i + 0x100) with a 3-cycle stall mid-stream.
      sent = 0; got = 0; cyc = 0; held = '0;
      while (got < 8 && cyc < 40) begin
         ordy = !(cyc >= 5 && cyc <= 7);
         drive(1, sent < 8, 64'(sent), 64'h100, 1'b0, 1'b0, ordy);
         sample(1, rdy, ov, s, co, of);
         if (!ordy) begin
            chk("stall_in_ready", 64'(rdy), 64'd0);
            chk("stall_out_valid", 64'(ov), 64'd1);
            if (cyc == 5) held = s;
            else chk("stall_hold", s, held);
         end else begin
            chk("run_in_ready", 64'(rdy), 64'd1);
         end
         if (ov && ordy) begin
            chk("stall_order", s, 64'h100 + 64'(got));
            got++;
         end
         if (sent < 8 && rdy) sent++;
         tick();
         cyc++;
      end
      chk("stall_count", 64'(got), 64'd8);
      chk("stall_held_val", held, 64'h101);

      // Reset mid-flight after two accepted beats.
      drive(1, 1'b1, 64'h10, 64'd0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1, 1'b1, 64'h20, 64'd0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      sample(1, rdy, ov, s, co, of);
      chk("midrst_out_valid", 64'(ov), 64'd0);
      chk("midrst_sum", s, 64'd0);
      chk("midrst_in_ready", 64'(rdy), 64'd1);
      tick();
      rst = 1'b0;
      sample(1, rdy, ov, s, co, of);
      chk("postrst_in_ready", 64'(rdy), 64'd1);
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         sample(1, rdy, ov, s, co, of);
         stale = stale | ov;
      end
      chk("postrst_stale", 64'(stale), 64'd0);
      run_one("fresh", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random regression with bubbles and backpressure at each width.
      for (int sel = 0; sel < 3; sel++) begin
         w   = (sel == 0) ? 4 : (sel == 1) ? 16 : 64;
         acc = 0;
         cyc = 0;
         exp_q.delete();
         while ((acc < 200 || exp_q.size() > 0) && cyc < 3000) begin
            v    = (acc < 200) && ($urandom_range(3) != 0);
            ordy = (acc >= 200) || ($urandom_range(3) != 0);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            ci   = 1'($urandom_range(1));
            sb   = 1'($urandom_range(1));
            drive(sel, v, a, b, ci, sb, ordy);
            sample(sel, rdy, ov, s, co, of);
            chk("reg_in_ready", 64'(rdy), 64'(!(ov && !ordy)));
            if (ov && ordy) begin
               if (exp_q.size() == 0) begin
                  chk("reg_spurious", 64'(ov), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("reg_sum", s, e[63:0]);
                  chk("reg_cout", 64'(co), 64'(e[64]));
                  chk("reg_ovf", 64'(of), 64'(e[65]));
               end
            end
            if (v && rdy) begin
               exp_q.push_back(model(w, a, b, ci, sb));
               acc++;
            end
            tick();
            cyc++;
         end
         chk("reg_accepted", 64'(acc), 64'd200);
         chk("reg_drained", 64'(exp_q.size()), 64'd0);
         drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
